axi_rd_stride_master: RTL and testbench



---
 rtl/axi_rd_stride_master.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_axi_rd_stride_master.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_stride_master.sv
// Generic synchronous FIFO used for small elastic buffers.
// Latency: a write is visible on rd_dat the cycle after it is accepted.
// Backpressure: writes are ignored while full; the caller gates on full.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_vld,
  input  logic [W-1:0]               wr_dat,
  input  logic                       rd_rdy,
  output logic [W-1:0]               rd_dat,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] cnt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign do_wr  = wr_vld && !full;
  assign do_rd  = rd_rdy && !empty;
  assign empty  = (cnt == '0);
  assign full   = (cnt == CW'(DEPTH));
  assign rd_dat = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_wr) - CW'(do_rd);
    end
  end

  // Storage array; contents need no reset since cnt qualifies them.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end
endmodule

// Strided AXI4 read master: one LSU command becomes cmd_num AR bursts spaced by cmd_stride.
// Latency: first AR one cycle after command accept; R beat to rsp_vld one cycle; done one cycle after last rsp.
// Backpressure: ARVALID waits for a free ID and a free outstanding slot; RREADY drops when the 2-entry skid is full.
module axi_rd_stride_master #(
  parameter int ID_W    = 4,
  parameter int MAX_OUT = 8,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  // LSU command
  input  logic                         cmd_vld,
  output logic                         cmd_rdy,
  input  logic [ADDR_W-1:0]            cmd_addr,
  input  logic [7:0]                   cmd_len,
  input  logic [2:0]                   cmd_size,
  input  logic [1:0]                   cmd_burst,
  input  logic [ADDR_W-1:0]            cmd_stride,
  input  logic [CNT_W-1:0]             cmd_num,
  // AXI AR channel
  output logic [ID_W-1:0]              ARID,
  output logic [ADDR_W-1:0]            ARADDR,
  output logic [7:0]                   ARLEN,
  output logic [2:0]                   ARSIZE,
  output logic [1:0]                   ARBURST,
  output logic [3:0]                   ARREGION,
  output logic                         ARVALID,
  input  logic                         ARREADY,
  // AXI R channel
  input  logic [ID_W-1:0]              RID,
  input  logic [DATA_W-1:0]            RDATA,
  input  logic [1:0]                   RRESP,
  input  logic                         RLAST,
  input  logic                         RVALID,
  output logic                         RREADY,
  // LSU response
  output logic                         rsp_vld,
  input  logic                         rsp_rdy,
  output logic [DATA_W-1:0]            rsp_data,
  output logic [1:0]                   rsp_resp,
  output logic                         rsp_last,
  output logic [CNT_W-1:0]             rsp_idx,
  // Status
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         unexp,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding
);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int NTAG  = 1 << ID_W;
  localparam int SKID  = 2;
  localparam int FC_W  = $clog2(SKID + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
    logic [CNT_W-1:0]  idx;
  } hdr_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state;
  state_t            state_nxt;

  // Latched command and issue progress
  logic [ADDR_W-1:0] addr_acc;
  logic [ADDR_W-1:0] stride_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  issue_cnt;
  logic              err_acc;

  // Tag table: which IDs are in flight and which burst index each carries.
  // Sized for the full ID space so a stray RID never indexes out of range;
  // entries at or above MAX_OUT are simply never set.
  logic [NTAG-1:0]   tag_vld;
  logic [CNT_W-1:0]  tag_idx [NTAG];

  logic              cmd_hs;
  logic              ar_ok;
  logic              ar_hs;
  logic              last_burst;
  logic              r_hs;
  logic              r_hit;
  logic              push_vld;
  logic              rlast_hit;
  logic              pop_rdy;
  logic [OUT_W-1:0]  out_nxt;
  logic [FC_W-1:0]   fifo_cnt;
  logic [FC_W-1:0]   fifo_cnt_nxt;
  logic              fifo_empty;
  logic              fifo_full;
  hdr_t              push_dat;
  hdr_t              pop_dat;

  assign cmd_hs     = (state == IDLE) && cmd_vld;
  // Only one burst per ID may be in flight, so a busy tag stalls issue.
  assign ar_ok      = !tag_vld[ARID] && (outstanding < OUT_W'(MAX_OUT));
  assign ar_hs      = (state == ISSUE) && ar_ok && ARREADY;
  assign last_burst = ((issue_cnt + CNT_W'(1)) == num_q);

  assign r_hs       = RVALID && RREADY;
  assign r_hit      = tag_vld[RID];
  assign push_vld   = r_hs && r_hit;
  assign rlast_hit  = push_vld && RLAST;
  assign pop_rdy    = rsp_vld && rsp_rdy;

  // Look-ahead values let DRAIN leave in the same cycle as the final response,
  // so done lands one cycle after the last rsp handshake.
  assign out_nxt      = outstanding + OUT_W'(ar_hs) - OUT_W'(rlast_hit);
  assign fifo_cnt_nxt = fifo_cnt + FC_W'(push_vld) - FC_W'(pop_rdy);

  assign ARADDR   = addr_acc;
  assign ARLEN    = len_q;
  assign ARSIZE   = size_q;
  assign ARBURST  = burst_q;
  assign ARREGION = 4'h0;
  assign RREADY   = !fifo_full;

  assign push_dat.data = RDATA;
  assign push_dat.resp = RRESP;
  assign push_dat.last = RLAST;
  assign push_dat.idx  = tag_idx[RID];

  assign rsp_vld  = !fifo_empty;
  assign rsp_data = pop_dat.data;
  assign rsp_resp = pop_dat.resp;
  assign rsp_last = pop_dat.last;
  assign rsp_idx  = pop_dat.idx;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state and Moore outputs.
  always_comb begin
    state_nxt = state;
    cmd_rdy   = 1'b0;
    ARVALID   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        busy    = 1'b0;
        cmd_rdy = 1'b1;
        if (cmd_vld) state_nxt = (cmd_num == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        ARVALID = ar_ok;
        if (ar_hs && last_burst) state_nxt = DRAIN;
      end
      DRAIN: begin
        if ((out_nxt == '0) && (fifo_cnt_nxt == '0)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        err       = err_acc;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, address accumulator, issue counter, ARID rotation and error accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_acc  <= '0;
      stride_q  <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      num_q     <= '0;
      issue_cnt <= '0;
      err_acc   <= 1'b0;
      ARID      <= '0;
    end else begin
      if (cmd_hs) begin
        addr_acc  <= cmd_addr;
        stride_q  <= cmd_stride;
        len_q     <= cmd_len;
        size_q    <= cmd_size;
        burst_q   <= cmd_burst;
        num_q     <= cmd_num;
        issue_cnt <= '0;
        err_acc   <= 1'b0;
      end else begin
        if (ar_hs) begin
          addr_acc  <= addr_acc + stride_q;
          issue_cnt <= issue_cnt + 1'b1;
        end
        if (push_vld && RRESP[1]) err_acc <= 1'b1;
      end
      // ARID keeps rotating across commands.
      if (ar_hs) ARID <= (ARID == ID_W'(MAX_OUT - 1)) ? '0 : ARID + 1'b1;
    end
  end

  // Tag valid bits: set on AR issue, cleared on RLAST acceptance.
  // Issue needs a free tag and retire needs a busy one, so they never hit the same ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
    end else begin
      if (rlast_hit) tag_vld[RID]  <= 1'b0;
      if (ar_hs)     tag_vld[ARID] <= 1'b1;
    end
  end

  // Burst index carried by each tag; qualified by tag_vld so no reset needed.
  always_ff @(posedge clk) begin
    if (ar_hs) tag_idx[ARID] <= issue_cnt;
  end

  // Live burst count and the stray-RID pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      unexp       <= 1'b0;
    end else begin
      outstanding <= out_nxt;
      unexp       <= r_hs && !r_hit;
    end
  end

  sync_fifo #(
    .W     ($bits(hdr_t)),
    .DEPTH (SKID)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (push_vld),
    .wr_dat (push_dat),
    .rd_rdy (rsp_rdy),
    .rd_dat (pop_dat),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .cnt    (fifo_cnt)
  );
endmodule

// File: tb/tb_axi_rd_stride_master.sv
// Directed bench for axi_rd_stride_master.
// Inputs change 1ns after the rising edge; every DUT output is registered-state
// driven, so they are sampled at the same point.
module tb_axi_rd_stride_master;
  localparam int ID_W    = 4;
  localparam int MAX_OUT = 8;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int CNT_W   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_vld;
  logic              cmd_rdy;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic [2:0]        cmd_size;
  logic [1:0]        cmd_burst;
  logic [ADDR_W-1:0] cmd_stride;
  logic [CNT_W-1:0]  cmd_num;
  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic [3:0]        ARREGION;
  logic              ARVALID;
  logic              ARREADY;
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;
  logic              rsp_vld;
  logic              rsp_rdy;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_resp;
  logic              rsp_last;
  logic [CNT_W-1:0]  rsp_idx;
  logic              busy;
  logic              done;
  logic              err;
  logic              unexp;
  logic [3:0]        outstanding;

  int checks = 0;
  int errors = 0;

  // Interleaved beat order for the backpressure test: (id, beat)
  logic [3:0] bp_id [8] = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd0, 4'd1, 4'd1, 4'd0};
  int         bp_bt [8] = '{0, 0, 1, 1, 2, 2, 3, 3};

  axi_rd_stride_master #(
    .ID_W(ID_W), .MAX_OUT(MAX_OUT), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_stride(cmd_stride), .cmd_num(cmd_num),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARREGION(ARREGION), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .rsp_last(rsp_last), .rsp_idx(rsp_idx),
    .busy(busy), .done(done), .err(err), .unexp(unexp), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [31:0] s, input logic [7:0] n,
                          input logic [7:0] l);
    chk("cmd_rdy_before_cmd", cmd_rdy, 1);
    cmd_vld = 1; cmd_addr = a; cmd_stride = s; cmd_num = n; cmd_len = l;
    cmd_size = 3'd3; cmd_burst = 2'd1;
    step();
    cmd_vld = 0;
  endtask

  task automatic r_beat(input logic [3:0] id, input logic [63:0] d, input logic [1:0] rr,
                        input logic lst);
    RVALID = 1; RID = id; RDATA = d; RRESP = rr; RLAST = lst;
  endtask

  initial begin
    int rptr;
    int optr;
    int cyc;
    logic acc;

    rst = 1; cmd_vld = 0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
    cmd_stride = '0; cmd_num = '0; ARREADY = 1; RID = '0; RDATA = '0; RRESP = '0;
    RLAST = 0; RVALID = 0; rsp_rdy = 1;
    step(); step();
    rst = 0;
    step();

    // Reset state
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_unexp", unexp, 0);
    chk("rst_rready", RREADY, 1);
    chk("rst_cmd_rdy", cmd_rdy, 1);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_arid", ARID, 0);
    chk("rst_arregion", ARREGION, 0);

    // Basic stride: 0x100 + i*0x40, IDs 0..3
    send_cmd(32'h100, 32'h40, 8'd4, 8'd0);
    chk("basic_busy", busy, 1);
    chk("basic_arlen", ARLEN, 0);
    chk("basic_arsize", ARSIZE, 3);
    chk("basic_arburst", ARBURST, 1);
    for (int i = 0; i < 4; i++) begin
      chk("basic_arvalid", ARVALID, 1);
      chk("basic_araddr", ARADDR, 64'h100 + 64'h40 * i);
      chk("basic_arid", ARID, i);
      step();
    end
    chk("basic_arvalid_off", ARVALID, 0);
    chk("basic_outstanding4", outstanding, 4);
    for (int i = 0; i < 4; i++) begin
      r_beat(4'(i), 64'hA0 + i, 2'd0, 1'b1);
      step();
      chk("basic_rsp_vld", rsp_vld, 1);
      chk("basic_rsp_data", rsp_data, 64'hA0 + i);
      chk("basic_rsp_idx", rsp_idx, i);
      chk("basic_rsp_last", rsp_last, 1);
    end
    RVALID = 0;
    step();
    chk("basic_done", done, 1);
    chk("basic_err", err, 0);
    chk("basic_outstanding0", outstanding, 0);
    step();
    chk("basic_done_pulse", done, 0);
    chk("basic_cmd_rdy_back", cmd_rdy, 1);

    // num = 0: no AR, done next cycle; ARID persists at 4
    send_cmd(32'h500, 32'h10, 8'd0, 8'd0);
    chk("num0_done", done, 1);
    chk("num0_arvalid", ARVALID, 0);
    step();
    chk("num0_done_pulse", done, 0);
    chk("num0_idle", cmd_rdy, 1);
    chk("num0_arid_kept", ARID, 4);

    // Address wrap and error accumulation
    send_cmd(32'h8, 32'hFFFF_FFF0, 8'd2, 8'd0);
    chk("wrap_addr0", ARADDR, 64'h8);
    chk("wrap_arid0", ARID, 4);
    step();
    chk("wrap_addr1", ARADDR, 64'hFFFF_FFF8);
    chk("wrap_arid1", ARID, 5);
    step();
    chk("wrap_arvalid_off", ARVALID, 0);
    r_beat(4'd4, 64'h11, 2'd2, 1'b1);
    step();
    chk("wrap_rsp_resp", rsp_resp, 2);
    chk("wrap_rsp_idx0", rsp_idx, 0);
    r_beat(4'd5, 64'h22, 2'd0, 1'b1);
    step();
    chk("wrap_rsp_idx1", rsp_idx, 1);
    RVALID = 0;
    step();
    chk("wrap_done", done, 1);
    chk("wrap_err", err, 1);
    step();

    // Reset with three bursts outstanding (IDs 6, 7, 0)
    send_cmd(32'h1000, 32'h10, 8'd3, 8'd0);
    step(); step(); step();
    chk("mid_outstanding3", outstanding, 3);
    rst = 1;
    step();
    rst = 0;
    chk("mid_outstanding_clr", outstanding, 0);
    chk("mid_arid_clr", ARID, 0);
    chk("mid_busy_clr", busy, 0);
    chk("mid_rready", RREADY, 1);
    r_beat(4'd7, 64'hDEAD, 2'd0, 1'b1);
    step();
    RVALID = 0;
    chk("mid_unexp", unexp, 1);
    chk("mid_rsp_vld", rsp_vld, 0);
    chk("mid_outstanding_stay", outstanding, 0);
    step();
    chk("mid_unexp_pulse", unexp, 0);

    // ID exhaustion: 12 bursts, R withheld
    send_cmd(32'h2000, 32'h100, 8'd12, 8'd0);
    for (int i = 0; i < 8; i++) begin
      chk("exh_arvalid", ARVALID, 1);
      chk("exh_arid", ARID, i);
      chk("exh_araddr", ARADDR, 64'h2000 + 64'h100 * i);
      step();
    end
    chk("exh_stall", ARVALID, 0);
    chk("exh_outstanding8", outstanding, 8);
    step();
    chk("exh_stall_hold", ARVALID, 0);
    r_beat(4'd0, 64'hC00, 2'd0, 1'b1);
    step();
    chk("exh_reissue_vld", ARVALID, 1);
    chk("exh_reissue_id", ARID, 0);
    chk("exh_reissue_addr", ARADDR, 64'h2800);
    chk("exh_outstanding7", outstanding, 7);
    chk("exh_rsp_idx0", rsp_idx, 0);
    for (int k = 1; k < 12; k++) begin
      r_beat(4'(k % 8), 64'hC00 + k, 2'd0, 1'b1);
      step();
      chk("exh_rsp_vld", rsp_vld, 1);
      chk("exh_rsp_idx", rsp_idx, k);
      chk("exh_rsp_data", rsp_data, 64'hC00 + k);
    end
    RVALID = 0;
    step();
    chk("exh_done", done, 1);
    chk("exh_err", err, 0);
    step();

    // Backpressure and interleave: len=3, IDs 0/1, rsp_rdy low for 5 cycles
    rst = 1;
    step();
    rst = 0;
    send_cmd(32'h3000, 32'h20, 8'd2, 8'd3);
    chk("bp_arlen", ARLEN, 3);
    step(); step();
    chk("bp_outstanding2", outstanding, 2);
    rptr = 0; optr = 0; cyc = 0;
    while (optr < 8 && cyc < 200) begin
      rsp_rdy = (cyc >= 5);
      if (cyc == 1) chk("bp_rsp_vld_next", rsp_vld, 1);
      if (cyc == 2) chk("bp_rready_low", RREADY, 0);
      if (cyc == 4) begin
        chk("bp_rready_still_low", RREADY, 0);
        chk("bp_two_buffered", rptr, 2);
      end
      if (rsp_vld && rsp_rdy) begin
        chk("bp_data", rsp_data, 64'h1000 + 64'(bp_id[optr]) * 16 + 64'(bp_bt[optr]));
        chk("bp_idx", rsp_idx, 64'(bp_id[optr]));
        chk("bp_last", rsp_last, (bp_bt[optr] == 3) ? 1 : 0);
        optr++;
      end
      acc = 0;
      if (rptr < 8) begin
        r_beat(bp_id[rptr], 64'h1000 + 64'(bp_id[rptr]) * 16 + 64'(bp_bt[rptr]), 2'd0,
               (bp_bt[rptr] == 3));
        acc = RREADY;
      end else begin
        RVALID = 0;
      end
      step();
      if (acc) rptr++;
      cyc++;
    end
    RVALID = 0;
    chk("bp_all_beats", optr, 8);
    chk("bp_done", done, 1);
    chk("bp_err", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
